// File: rtl/event_window_gen5.sv
// Sparse pixel events -> frame map -> packed 5x5 neighbourhood window.
// Optional EVENT_WINDOW_ACCUM_EN: saturating read-modify-write instead of overwrite.
module event_window_gen5 #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned IMG_W      = 64,
  parameter int unsigned IMG_H      = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_event_valid,
  input  logic [15:0]              in_event_addr,
  input  logic [DATA_WIDTH-1:0]    in_event_value,
  output logic                     in_event_ready,
  input  logic                     window_req,
  output logic [DATA_WIDTH*25-1:0] out_window_value,
  output logic                     out_window_valid,
  output logic [15:0]              out_window_addr
);

  localparam int unsigned WIN_W  = DATA_WIDTH * 25;
  localparam int unsigned DEPTH  = IMG_W * IMG_H;
  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [8:0] IMG_W9  = 9'(IMG_W);
  localparam logic [8:0] IMG_H9  = 9'(IMG_H);
  localparam logic [9:0] IMG_W10 = 10'(IMG_W);
  localparam logic [9:0] IMG_H10 = 10'(IMG_H);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_FETCH   = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_PRESENT = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [7:0]            ev_x_q, ev_y_q;
  logic [DATA_WIDTH-1:0] ev_val_q;
  logic [4:0]            k_q;
  logic [2:0]            row_q, col_q;
  logic                  cap_en_q, nb_rd_q;
  logic [4:0]            cap_k_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [WIN_W-1:0]      win_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept_c, strobe_c;
  logic                  rd_en_c, wr_en_c;
  logic [ADDR_W-1:0]     rd_addr_c, wr_addr_c, nb_addr_c;
  logic [DATA_WIDTH-1:0] wr_data_c, cap_data_c;
  logic                  in_frame_c, nb_ok_c;
  logic [9:0]            nxp_c, nyp_c, nx_c, ny_c;
  logic [19:0]           nb_lin_c, ctr_lin_c;
  logic [WIN_W-1:0]      win_full_c;

  // Event centre and current neighbour (offset by +2 so the arithmetic stays unsigned)
  always_comb begin
    in_frame_c = ({1'b0, ev_x_q} < IMG_W9) && ({1'b0, ev_y_q} < IMG_H9);
    nxp_c      = 10'(ev_x_q) + 10'(col_q);
    nyp_c      = 10'(ev_y_q) + 10'(row_q);
    nb_ok_c    = (nxp_c >= 10'd2) && (nxp_c < IMG_W10 + 10'd2) &&
                 (nyp_c >= 10'd2) && (nyp_c < IMG_H10 + 10'd2);
    nx_c       = nxp_c - 10'd2;
    ny_c       = nyp_c - 10'd2;
    nb_lin_c   = 20'(ny_c) * 20'(IMG_W) + 20'(nx_c);
    ctr_lin_c  = 20'(ev_y_q) * 20'(IMG_W) + 20'(ev_x_q);
    nb_addr_c  = ADDR_W'(nb_lin_c);
    wr_addr_c  = ADDR_W'(ctr_lin_c);
  end

`ifdef EVENT_WINDOW_ACCUM_EN
  logic [DATA_WIDTH:0] sum_c;
  always_comb begin
    sum_c     = {1'b0, rdata_q} + {1'b0, ev_val_q};
    wr_data_c = sum_c[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : sum_c[DATA_WIDTH-1:0];
  end
`else
  always_comb wr_data_c = ev_val_q;
`endif

  // Merge the element arriving from the read port into the window being assembled
  always_comb begin
    cap_data_c = nb_rd_q ? rdata_q : '0;
    win_full_c = win_q;
    for (int k = 0; k < 25; k++) begin
      if (cap_en_q && (cap_k_q == 5'(k))) begin
        win_full_c[DATA_WIDTH*k +: DATA_WIDTH] = cap_data_c;
      end
    end
  end

  // Next state and memory port controls
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    strobe_c  = 1'b0;
    rd_en_c   = 1'b0;
    wr_en_c   = 1'b0;
    rd_addr_c = nb_addr_c;
    case (state_q)
      S_IDLE: begin
        if (in_event_ready && in_event_valid) begin
          accept_c = 1'b1;
`ifdef EVENT_WINDOW_ACCUM_EN
          state_d  = S_READ;
`else
          state_d  = S_WRITE;
`endif
        end
      end
      S_READ: begin
        rd_en_c   = in_frame_c;
        rd_addr_c = wr_addr_c;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        if (in_frame_c) begin
          wr_en_c = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        rd_en_c = nb_ok_c;
        if (k_q == 5'd24) state_d = S_DRAIN;
      end
      // DRAIN already presents: a waiting filter gets the window as the last read lands
      S_DRAIN, S_PRESENT: begin
        if (window_req) begin
          strobe_c = 1'b1;
          state_d  = S_IDLE;
        end else begin
          state_d  = S_PRESENT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      ev_x_q           <= '0;
      ev_y_q           <= '0;
      ev_val_q         <= '0;
      k_q              <= '0;
      row_q            <= '0;
      col_q            <= '0;
      cap_en_q         <= 1'b0;
      nb_rd_q          <= 1'b0;
      cap_k_q          <= '0;
      win_q            <= '0;
      in_event_ready   <= 1'b0;
      out_window_valid <= 1'b0;
      out_window_value <= '0;
      out_window_addr  <= '0;
    end else begin
      state_q          <= state_d;
      in_event_ready   <= (state_d == S_IDLE);
      out_window_valid <= strobe_c;
      if (accept_c) begin
        ev_x_q   <= in_event_addr[7:0];
        ev_y_q   <= in_event_addr[15:8];
        ev_val_q <= in_event_value;
      end
      if (state_q == S_WRITE) begin
        k_q   <= '0;
        row_q <= '0;
        col_q <= '0;
      end else if (state_q == S_FETCH) begin
        k_q <= k_q + 5'd1;
        if (col_q == 3'd4) begin
          col_q <= '0;
          row_q <= row_q + 3'd1;
        end else begin
          col_q <= col_q + 3'd1;
        end
      end
      cap_en_q <= (state_q == S_FETCH);
      nb_rd_q  <= (state_q == S_FETCH) && nb_ok_c;
      cap_k_q  <= k_q;
      win_q    <= win_full_c;
      if (strobe_c) begin
        out_window_value <= win_full_c;
        out_window_addr  <= {ev_y_q, ev_x_q};
      end
    end
  end

  // Frame map: one write port, one synchronous read port; contents survive reset
  always_ff @(posedge clk) begin
    if (rst_n && wr_en_c) mem[wr_addr_c] <= wr_data_c;
    if (rst_n && rd_en_c) rdata_q <= mem[rd_addr_c];
  end

endmodule

// File: tb/tb_event_window_gen5.sv
// Randomised and directed check of event_window_gen5 against a frame-map reference model.
module tb_event_window_gen5;

  localparam int DW    = 4;
  localparam int IMG_W = 64;
  localparam int IMG_H = 64;
  localparam int WIN_W = DW * 25;
`ifdef EVENT_WINDOW_ACCUM_EN
  localparam int LAT = 28;
`else
  localparam int LAT = 27;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_event_valid;
  logic [15:0]      in_event_addr;
  logic [DW-1:0]    in_event_value;
  logic             in_event_ready;
  logic             window_req;
  logic [WIN_W-1:0] out_window_value;
  logic             out_window_valid;
  logic [15:0]      out_window_addr;

  int vectors    = 0;
  int miscompares = 0;
  int model_mem [IMG_W*IMG_H];

  event_window_gen5 #(.DATA_WIDTH(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_event_valid   (in_event_valid),
    .in_event_addr    (in_event_addr),
    .in_event_value   (in_event_value),
    .in_event_ready   (in_event_ready),
    .window_req       (window_req),
    .out_window_value (out_window_value),
    .out_window_valid (out_window_valid),
    .out_window_addr  (out_window_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_frame(input int x, input int y);
    return (x >= 0) && (x < IMG_W) && (y >= 0) && (y < IMG_H);
  endfunction

  function automatic void model_write(input int x, input int y, input int v);
    int s;
    if (!in_frame(x, y)) return;
`ifdef EVENT_WINDOW_ACCUM_EN
    s = model_mem[y*IMG_W+x] + v;
    if (s > (1 << DW) - 1) s = (1 << DW) - 1;
`else
    s = v;
`endif
    model_mem[y*IMG_W+x] = s;
  endfunction

  function automatic logic [WIN_W-1:0] exp_window(input int x, input int y);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (in_frame(x + c - 2, y + r - 2))
          w[DW*(r*5+c) +: DW] = DW'(model_mem[(y+r-2)*IMG_W + (x+c-2)]);
      end
    end
    return w;
  endfunction

  task automatic offer(input int x, input int y, input int v);
    int n;
    n = 0;
    while (!in_event_ready && n < 100) begin
      tick();
      n++;
    end
    check("ready_before_event", 128'(in_event_ready), 128'(1));
    in_event_valid = 1'b1;
    in_event_addr  = {8'(y), 8'(x)};
    in_event_value = DW'(v);
    @(posedge clk);
    #1;
    in_event_valid = 1'b0;
    model_write(x, y, v);
    check("ready_after_accept", 128'(in_event_ready), 128'(0));
  endtask

  // One full event with window_req held high
  task automatic do_event(input int x, input int y, input int v);
    int n;
    bit seen, extra;
    offer(x, y, v);
    if (in_frame(x, y)) begin
      n = 0;
      seen = 1'b0;
      while (!seen && n < 60) begin
        tick();
        n++;
        if (out_window_valid) seen = 1'b1;
      end
      check("strobe_latency", 128'(n), 128'(LAT));
      check("window_value", 128'(out_window_value), 128'(exp_window(x, y)));
      check("window_addr", 128'(out_window_addr), 128'({8'(y), 8'(x)}));
      tick();
      check("strobe_one_cycle", 128'(out_window_valid), 128'(0));
    end else begin
      tick();
      check("ready_after_bad_addr", 128'(in_event_ready), 128'(1));
      extra = 1'b0;
      for (int i = 0; i < 35; i++) begin
        if (out_window_valid) extra = 1'b1;
        tick();
      end
      check("no_strobe_bad_addr", 128'(extra), 128'(0));
    end
  endtask

  initial begin
    logic [WIN_W-1:0] hold_val;
    logic [15:0]      hold_addr;
    bit               bad;
    int               x, y, v;

    for (int i = 0; i < IMG_W*IMG_H; i++) model_mem[i] = 0;
    rst_n          = 1'b0;
    in_event_valid = 1'b0;
    in_event_addr  = '0;
    in_event_value = '0;
    window_req     = 1'b1;
    repeat (3) tick();
    check("reset_ready", 128'(in_event_ready), 128'(0));
    check("reset_valid", 128'(out_window_valid), 128'(0));
    check("reset_value", 128'(out_window_value), 128'(0));
    check("reset_addr", 128'(out_window_addr), 128'(0));
    rst_n = 1'b1;
    tick();
    check("ready_after_reset", 128'(in_event_ready), 128'(1));

    // Directed: single event, neighbour plus re-write, frame corner, far corner
    do_event(10, 10, 5);
    do_event(11, 10, 3);
    do_event(10, 10, 7);
    check("t2_k12", 128'(out_window_value[DW*12 +: DW]), 128'(7));
    check("t2_k13", 128'(out_window_value[DW*13 +: DW]), 128'(3));
    do_event(0, 0, 9);
    do_event(63, 63, 12);

    // Held-off window request: FSM stalls with ready low, strobes the cycle after request
    window_req = 1'b0;
    offer(20, 30, 6);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (in_event_ready || out_window_valid) bad = 1'b1;
    end
    check("stall_ready_valid_low", 128'(bad), 128'(0));
    hold_val  = out_window_value;
    hold_addr = out_window_addr;
    check("stall_value_holds", 128'(hold_val), 128'(exp_window(63, 63)));
    check("stall_addr_holds", 128'(hold_addr), 128'(16'h3F3F));
    window_req = 1'b1;
    tick();
    check("stall_strobe", 128'(out_window_valid), 128'(1));
    check("stall_value", 128'(out_window_value), 128'(exp_window(20, 30)));
    check("stall_addr", 128'(out_window_addr), 128'(16'h1E14));
    tick();
    check("stall_strobe_once", 128'(out_window_valid), 128'(0));

    // Out-of-frame event, then confirm linear index 64 (x=0,y=1) was not written
    do_event(64, 0, 15);
    do_event(1, 1, 4);
    do_event(5, 70, 8);

    // Reset in the middle of FETCH
    offer(30, 40, 11);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    check("midreset_valid", 128'(out_window_valid), 128'(0));
    check("midreset_ready", 128'(in_event_ready), 128'(0));
    check("midreset_value", 128'(out_window_value), 128'(0));
    check("midreset_addr", 128'(out_window_addr), 128'(0));
    rst_n = 1'b1;
    tick();
    check("midreset_ready_release", 128'(in_event_ready), 128'(1));
    bad = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (out_window_valid) bad = 1'b1;
      tick();
    end
    check("midreset_no_strobe", 128'(bad), 128'(0));
    do_event(31, 40, 2);

`ifdef EVENT_WINDOW_ACCUM_EN
    do_event(5, 5, 10);
    do_event(5, 5, 9);
    check("accum_saturate_k12", 128'(out_window_value[DW*12 +: DW]), 128'(15));
`endif

    // Randomised events clustered in a small region so neighbourhoods overlap
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        x = $urandom_range(60, 80);
        y = $urandom_range(60, 80);
      end else begin
        x = $urandom_range(0, 12);
        y = $urandom_range(0, 12);
        if ($urandom_range(0, 1) == 1) begin
          x = x + 51;
          y = y + 51;
        end
      end
      v = $urandom_range(0, 15);
      do_event(x, y, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
